// File: rtl/ram_pkg.sv
// ram_pkg: shared RAM geometry, read-engine state encoding and burst length type
package ram_pkg;
  localparam int RAM_AWL = 8;
  localparam int RAM_DEPTH = 256;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} rd_state_t;
  typedef logic [RAM_AWL:0] ram_len_t;
endpackage

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: sweeps length words from start_addr (wrapping) out of a 256-deep comb-read RAM via ram_addr/ram_rd_data onto an m_data/m_valid/m_last/m_ready stream, with start command and busy/done status
module ram_burst_reader
  import ram_pkg::*;
#(
  parameter int DWL = 32,
  parameter int AWL = RAM_AWL
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [AWL-1:0] start_addr,
  input  logic [AWL:0]   length,
  output logic           busy,
  output logic           done,
  output logic [AWL-1:0] ram_addr,
  input  logic [DWL-1:0] ram_rd_data,
  output logic [DWL-1:0] m_data,
  output logic           m_valid,
  output logic           m_last,
  input  logic           m_ready
);
  localparam logic [AWL:0] MAX_LEN = {1'b1, {AWL{1'b0}}};
  rd_state_t state, state_nx;
  logic [AWL:0] remaining;
  logic accept, zero, load, fin;
  always_comb begin
    accept = state == IDLE && start && length != '0;
    zero = state == IDLE && start && length == '0;
    load = state == READ && (!m_valid || m_ready);
    fin = state == DRAIN && m_valid && m_ready;
    state_nx = accept ? READ : (load && remaining == (AWL+1)'(1)) ? DRAIN : fin ? IDLE : state;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ram_addr <= '0;
      remaining <= '0;
      m_data <= '0;
      m_valid <= 1'b0;
      m_last <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      done <= zero || fin;
      if (accept) begin
        ram_addr <= start_addr;
        remaining <= length > MAX_LEN ? MAX_LEN : length;
      end
      if (load) begin
        m_data <= ram_rd_data;
        m_valid <= 1'b1;
        m_last <= remaining == (AWL+1)'(1);
        ram_addr <= ram_addr + AWL'(1);
        remaining <= remaining - (AWL+1)'(1);
      end
      if (fin) begin
        m_valid <= 1'b0;
        m_last <= 1'b0;
      end
    end
  end
endmodule
